// File: rtl/uart_frame_loader_pkg.sv
// Shared LED cube definitions: protocol bytes, frame size
// and the packet parser state encoding.
package uart_frame_loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] CMD_FRAME = 8'h01;
    localparam logic [7:0] CMD_POKE  = 8'h02;
    localparam logic [7:0] RESP_ACK  = 8'h06;
    localparam logic [7:0] RESP_NAK  = 8'h15;
    localparam int         FB_DEPTH  = 512;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR_HI,
        ST_ADDR_LO,
        ST_PAYLOAD,
        ST_CHECK,
        ST_RESP
    } state_t;

endpackage

// File: rtl/uart_frame_loader_if.sv
// UART rx/tx handshake, BRAM write port and status lines
// of the frame loader, bundled for the top-level port.
interface uart_frame_loader_if #(
    parameter int ADDR_WIDTH = 9
);

    logic                  rx_valid;
    logic [7:0]            rx_data;
    logic                  tx_valid;
    logic [7:0]            tx_data;
    logic                  tx_ready;
    logic [0:0]            bram_write_enable;
    logic [ADDR_WIDTH-1:0] bram_write_addr;
    logic [7:0]            bram_write_data;
    logic                  frame_done;
    logic                  frame_error;
    logic                  busy;

    modport master (
        input  rx_valid, rx_data, tx_ready,
        output tx_valid, tx_data,
        output bram_write_enable, bram_write_addr,
        output bram_write_data,
        output frame_done, frame_error, busy
    );

    modport slave (
        output rx_valid, rx_data, tx_ready,
        input  tx_valid, tx_data,
        input  bram_write_enable, bram_write_addr,
        input  bram_write_data,
        input  frame_done, frame_error, busy
    );

endinterface

// File: rtl/uart_frame_loader_idle_timer.sv
// Inter-byte idle counter: expires on the CYCLES-th consecutive
// enabled cycle without a clear; held at zero while disabled.
module idle_timer #(
    parameter int CYCLES = 1000000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // A clearing byte in the expiry cycle wins over the timeout.
    always_comb begin
        expired = enable && !clear && (cnt_q == LAST);
        if (!enable || clear || expired) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Idle count register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_frame_loader.sv
// Parses A5-framed UART packets into frame-buffer BRAM writes
// and answers each packet with a single ACK/NAK byte.
module uart_frame_loader
    import uart_frame_loader_pkg::*;
#(
    parameter int DEPTH          = FB_DEPTH,
    parameter int ADDR_WIDTH     = 9,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                clock,
    input  logic                reset,
    uart_frame_loader_if.master bus
);

    localparam int REM_W = ADDR_WIDTH + 1;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [REM_W-1:0]      rem_q, rem_d;
    logic [7:0]            sum_q, sum_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] wa_q, wa_d;
    logic [7:0]            wd_q, wd_d;
    logic                  tx_valid_q, tx_valid_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;

    logic timed;
    logic expired;

    // Timeout only runs while a packet is being parsed.
    assign timed = state_q inside {ST_CMD, ST_ADDR_HI, ST_ADDR_LO,
                                   ST_PAYLOAD, ST_CHECK};

    idle_timer #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (bus.rx_valid),
        .enable  (timed),
        .expired (expired)
    );

    // Packet parser next-state, checksum and write strobe logic.
    always_comb begin
        logic [7:0] sum_nx;
        logic       ack;
        logic       nak;
        sum_nx     = sum_q + bus.rx_data;
        ack        = 1'b0;
        nak        = 1'b0;
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        sum_d      = sum_q;
        we_d       = 1'b0;
        wa_d       = wa_q;
        wd_d       = wd_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        done_d     = 1'b0;
        error_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.rx_valid && bus.rx_data == SYNC_BYTE) begin
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                if (bus.rx_valid) begin
                    sum_d = bus.rx_data;
                    if (bus.rx_data == CMD_FRAME) begin
                        addr_d  = '0;
                        rem_d   = REM_W'(DEPTH);
                        state_d = ST_PAYLOAD;
                    end else if (bus.rx_data == CMD_POKE) begin
                        state_d = ST_ADDR_HI;
                    end else begin
                        nak = 1'b1;
                    end
                end else if (expired) begin
                    nak = 1'b1;
                end
            end
            ST_ADDR_HI: begin
                if (bus.rx_valid) begin
                    sum_d   = sum_nx;
                    addr_d  = ADDR_WIDTH'({bus.rx_data, 8'h00});
                    state_d = ST_ADDR_LO;
                end else if (expired) begin
                    nak = 1'b1;
                end
            end
            ST_ADDR_LO: begin
                if (bus.rx_valid) begin
                    sum_d   = sum_nx;
                    addr_d  = {addr_q[ADDR_WIDTH-1:8], bus.rx_data};
                    rem_d   = REM_W'(1);
                    state_d = ST_PAYLOAD;
                end else if (expired) begin
                    nak = 1'b1;
                end
            end
            ST_PAYLOAD: begin
                if (bus.rx_valid) begin
                    sum_d  = sum_nx;
                    we_d   = 1'b1;
                    wa_d   = addr_q;
                    wd_d   = bus.rx_data;
                    addr_d = addr_q + 1'b1;
                    rem_d  = rem_q - 1'b1;
                    if (rem_q == REM_W'(1)) begin
                        state_d = ST_CHECK;
                    end
                end else if (expired) begin
                    nak = 1'b1;
                end
            end
            ST_CHECK: begin
                if (bus.rx_valid) begin
                    sum_d = sum_nx;
                    if (sum_nx == 8'h00) begin
                        ack = 1'b1;
                    end else begin
                        nak = 1'b1;
                    end
                end else if (expired) begin
                    nak = 1'b1;
                end
            end
            ST_RESP: begin
                if (bus.tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (ack || nak) begin
            state_d    = ST_RESP;
            tx_valid_d = 1'b1;
            tx_data_d  = ack ? RESP_ACK : RESP_NAK;
            done_d     = ack;
            error_d    = nak;
        end
    end

    // Parser state and registered outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            sum_q      <= '0;
            we_q       <= 1'b0;
            wa_q       <= '0;
            wd_q       <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            sum_q      <= sum_d;
            we_q       <= we_d;
            wa_q       <= wa_d;
            wd_q       <= wd_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign bus.bram_write_enable = we_q;
    assign bus.bram_write_addr   = wa_q;
    assign bus.bram_write_data   = wd_q;
    assign bus.tx_valid          = tx_valid_q;
    assign bus.tx_data           = tx_data_q;
    assign bus.frame_done        = done_q;
    assign bus.frame_error       = error_q;
    assign bus.busy              = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_frame_loader.sv
// Bench for uart_frame_loader: vector table, hand-written
// corner sequences and random packets against a packet model.
module tb_uart_frame_loader;

    localparam int TMO = 100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_frame_loader_if #(.ADDR_WIDTH(9)) bus ();

    uart_frame_loader #(
        .DEPTH          (512),
        .ADDR_WIDTH     (9),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] hi;
        logic [7:0] lo;
        logic [7:0] dat;
        logic [7:0] csd;
        int         gap;
        logic [7:0] resp;
        int         nwr;
        logic [8:0] wa;
        logic [7:0] wd;
        int         ndone;
        int         nerr;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic [8:0] wr_a[$];
    logic [7:0] wr_d[$];
    logic [8:0] ex_a[$];
    logic [7:0] ex_d[$];
    logic [7:0] dut_mem[512];
    logic [7:0] ref_mem[512];
    int done_cnt, err_cnt, both_cnt, txv_cnt;

    // Observe DUT outputs on the falling edge.
    always @(negedge clk) begin
        if (bus.bram_write_enable == 1'b1) begin
            wr_a.push_back(bus.bram_write_addr);
            wr_d.push_back(bus.bram_write_data);
            dut_mem[bus.bram_write_addr] = bus.bram_write_data;
        end
        if (bus.frame_done) done_cnt++;
        if (bus.frame_error) err_cnt++;
        if (bus.frame_done && bus.frame_error) both_cnt++;
        if (bus.tx_valid) txv_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clr();
        wr_a.delete();
        wr_d.delete();
        ex_a.delete();
        ex_d.delete();
        done_cnt = 0;
        err_cnt = 0;
        txv_cnt = 0;
    endtask

    task automatic expect_write(input logic [8:0] a, input logic [7:0] d);
        ex_a.push_back(a);
        ex_d.push_back(d);
        ref_mem[a] = d;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bus.rx_valid = 1'b1;
        bus.rx_data = b;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_pkt(input logic [7:0] p[$], input int gmin,
                            input int gmax);
        for (int i = 0; i < p.size(); i++) begin
            int g;
            g = (i == p.size() - 1) ? 0 : int'($urandom_range(gmax, gmin));
            send_byte(p[i], g);
        end
    endtask

    // Packet-level rule: ACK iff the command is known and the byte
    // sum after the sync byte is zero modulo 256.
    function automatic logic [7:0] ref_resp(input logic [7:0] p[$],
                                            input bit cmd_ok);
        logic [7:0] s;
        s = 8'h00;
        for (int i = 1; i < p.size(); i++) s = s + p[i];
        return (cmd_ok && s == 8'h00) ? 8'h06 : 8'h15;
    endfunction

    function automatic logic [7:0] neg_sum(input logic [7:0] p[$]);
        logic [7:0] s;
        s = 8'h00;
        for (int i = 1; i < p.size(); i++) s = s + p[i];
        return 8'h00 - s;
    endfunction

    task automatic get_resp(input string name, input logic [7:0] exp,
                            input int delay, input bit inject,
                            output int waited);
        logic [7:0] resp;
        int stable_bad;
        waited = 0;
        stable_bad = 0;
        while (bus.tx_valid !== 1'b1 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        chk({name, " tx_valid"}, 32'(bus.tx_valid), 32'd1);
        chk({name, " tx_data"}, 32'(bus.tx_data), 32'(exp));
        resp = bus.tx_data;
        for (int i = 0; i < delay; i++) begin
            bus.rx_valid = inject;
            bus.rx_data = i[0] ? 8'h01 : 8'hA5;
            @(negedge clk);
            if (bus.tx_valid !== 1'b1 || bus.tx_data !== resp) stable_bad++;
        end
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b1;
        @(negedge clk);
        bus.tx_ready = 1'b0;
        chk({name, " tx stable"}, 32'(stable_bad), 32'd0);
        chk({name, " tx_valid fall"}, 32'(bus.tx_valid), 32'd0);
        chk({name, " busy after"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic check_writes(input string name);
        int bad;
        int n;
        bad = 0;
        chk({name, " nwr"}, 32'(wr_a.size()), 32'(ex_a.size()));
        n = (wr_a.size() < ex_a.size()) ? wr_a.size() : ex_a.size();
        for (int i = 0; i < n; i++) begin
            if (wr_a[i] !== ex_a[i] || wr_d[i] !== ex_d[i]) bad++;
        end
        chk({name, " wr contents"}, 32'(bad), 32'd0);
    endtask

    task automatic check_pulses(input string name, input int d,
                                input int e);
        chk({name, " frame_done"}, 32'(done_cnt), 32'(d));
        chk({name, " frame_error"}, 32'(err_cnt), 32'(e));
    endtask

    task automatic run_frame(input string name, input logic [7:0] pay[512],
                             input logic [7:0] csd, input int gmax,
                             input int delay, input bit inject);
        logic [7:0] p[$];
        logic [7:0] r;
        int w;
        clr();
        p.push_back(8'hA5);
        p.push_back(8'h01);
        for (int k = 0; k < 512; k++) begin
            p.push_back(pay[k]);
            expect_write(9'(k), pay[k]);
        end
        p.push_back(neg_sum(p) + csd);
        r = ref_resp(p, 1'b1);
        send_pkt(p, 0, gmax);
        get_resp(name, r, delay, inject, w);
        check_writes(name);
        check_pulses(name, (r == 8'h06) ? 1 : 0, (r == 8'h06) ? 0 : 1);
    endtask

    vec_t vt[9];
    logic [7:0] pay[512];
    logic [7:0] p[$];
    int w;

    initial begin
        vt[0] = '{8'h02, 8'h01, 8'h2C, 8'h7F, 8'h00, 0,
                  8'h06, 1, 9'h12C, 8'h7F, 1, 0};
        vt[1] = '{8'h02, 8'h00, 8'h00, 8'hFF, 8'h00, 1,
                  8'h06, 1, 9'h000, 8'hFF, 1, 0};
        vt[2] = '{8'h02, 8'hFF, 8'hFF, 8'h01, 8'h00, 2,
                  8'h06, 1, 9'h1FF, 8'h01, 1, 0};
        vt[3] = '{8'h02, 8'hFE, 8'h10, 8'h55, 8'h00, 0,
                  8'h06, 1, 9'h010, 8'h55, 1, 0};
        vt[4] = '{8'h02, 8'h01, 8'h2C, 8'h7F, 8'h01, 0,
                  8'h15, 1, 9'h12C, 8'h7F, 0, 1};
        vt[5] = '{8'h09, 8'h01, 8'h2C, 8'h7F, 8'h00, 0,
                  8'h15, 0, 9'h000, 8'h00, 0, 1};
        vt[6] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0,
                  8'h15, 0, 9'h000, 8'h00, 0, 1};
        vt[7] = '{8'h02, 8'h01, 8'h00, 8'hAA, 8'h00, TMO - 1,
                  8'h06, 1, 9'h100, 8'hAA, 1, 0};
        vt[8] = '{8'h02, 8'h01, 8'h00, 8'hBB, 8'h00, TMO,
                  8'h15, 0, 9'h000, 8'h00, 0, 1};

        bus.rx_valid = 1'b0;
        bus.rx_data = 8'h00;
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 512; i++) begin
            dut_mem[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
        both_cnt = 0;
        clr();

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst tx_valid", 32'(bus.tx_valid), 32'd0);
        chk("rst tx_data", 32'(bus.tx_data), 32'd0);
        chk("rst we", 32'(bus.bram_write_enable), 32'd0);
        chk("rst waddr", 32'(bus.bram_write_addr), 32'd0);
        chk("rst wdata", 32'(bus.bram_write_data), 32'd0);
        chk("rst done", 32'(bus.frame_done), 32'd0);
        chk("rst error", 32'(bus.frame_error), 32'd0);
        chk("rst busy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int r = 0; r < 9; r++) begin
            string nm;
            nm = $sformatf("vec%0d", r);
            clr();
            p.delete();
            p.push_back(8'hA5);
            p.push_back(vt[r].cmd);
            p.push_back(vt[r].hi);
            p.push_back(vt[r].lo);
            p.push_back(vt[r].dat);
            p.push_back(neg_sum(p) + vt[r].csd);
            send_pkt(p, vt[r].gap, vt[r].gap);
            if (vt[r].nwr > 0) expect_write(vt[r].wa, vt[r].wd);
            get_resp(nm, vt[r].resp, 0, 1'b0, w);
            check_writes(nm);
            check_pulses(nm, vt[r].ndone, vt[r].nerr);
        end

        clr();
        p.delete();
        p.push_back(8'hA5);
        p.push_back(8'h09);
        send_pkt(p, 0, 0);
        get_resp("unknown", 8'h15, 0, 1'b0, w);
        check_writes("unknown");
        check_pulses("unknown", 0, 1);

        for (int k = 0; k < 512; k++) pay[k] = 8'(k);
        run_frame("frame bp", pay, 8'h00, 0, 50, 1'b1);
        run_frame("frame badcs", pay, 8'h01, 0, 0, 1'b0);

        clr();
        p.delete();
        p.push_back(8'hA5);
        p.push_back(8'h01);
        for (int k = 0; k < 10; k++) begin
            p.push_back(8'(k + 8'h40));
            expect_write(9'(k), 8'(k + 8'h40));
        end
        send_pkt(p, 0, 0);
        get_resp("timeout", 8'h15, 0, 1'b0, w);
        chk("timeout latency", 32'(w), 32'(TMO));
        check_writes("timeout");
        check_pulses("timeout", 0, 1);

        clr();
        p.delete();
        p.push_back(8'hA5);
        p.push_back(8'h01);
        for (int k = 0; k < 100; k++) begin
            p.push_back(8'(k) ^ 8'h3C);
            expect_write(9'(k), 8'(k) ^ 8'h3C);
        end
        send_pkt(p, 0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst we", 32'(bus.bram_write_enable), 32'd0);
        chk("midrst waddr", 32'(bus.bram_write_addr), 32'd0);
        chk("midrst wdata", 32'(bus.bram_write_data), 32'd0);
        chk("midrst busy", 32'(bus.busy), 32'd0);
        chk("midrst tx", 32'({bus.tx_valid, bus.tx_data}), 32'd0);
        chk("midrst pulses", 32'({bus.frame_done, bus.frame_error}), 32'd0);
        rst_n = 1'b1;
        repeat (2 * TMO) @(negedge clk);
        chk("midrst no resp", 32'(txv_cnt), 32'd0);
        check_writes("midrst");
        check_pulses("midrst", 0, 0);

        for (int n = 0; n < 10; n++) begin
            string nm;
            int kind;
            bit cmd_ok;
            logic [7:0] r;
            nm = $sformatf("rnd%0d", n);
            kind = $urandom_range(3, 0);
            clr();
            repeat ($urandom_range(2, 0)) begin
                logic [7:0] g;
                g = 8'($urandom);
                if (g == 8'hA5) g = 8'h00;
                send_byte(g, $urandom_range(1, 0));
            end
            p.delete();
            p.push_back(8'hA5);
            cmd_ok = 1'b1;
            if (kind == 2) begin
                p.push_back(8'h01);
                for (int k = 0; k < 512; k++) begin
                    logic [7:0] d;
                    d = 8'($urandom);
                    p.push_back(d);
                    expect_write(9'(k), d);
                end
            end else if (kind == 3) begin
                cmd_ok = 1'b0;
                p.push_back(8'($urandom_range(255, 3)));
                repeat (3) p.push_back(8'($urandom));
            end else begin
                logic [7:0] hi, lo, d;
                hi = 8'($urandom);
                lo = 8'($urandom);
                d = 8'($urandom);
                p.push_back(8'h02);
                p.push_back(hi);
                p.push_back(lo);
                p.push_back(d);
                expect_write({hi[0], lo}, d);
            end
            p.push_back(neg_sum(p));
            if ($urandom_range(3, 0) == 0) begin
                p[p.size() - 1] = p[p.size() - 1] + 8'($urandom_range(255, 1));
            end
            r = ref_resp(p, cmd_ok);
            send_pkt(p, 0, (kind == 2) ? 1 : 5);
            get_resp(nm, r, $urandom_range(6, 0), 1'($urandom), w);
            check_writes(nm);
            check_pulses(nm, (r == 8'h06) ? 1 : 0, (r == 8'h06) ? 0 : 1);
        end

        begin
            int bad;
            bad = 0;
            for (int i = 0; i < 512; i++) begin
                if (dut_mem[i] !== ref_mem[i]) bad++;
            end
            chk("memory image", 32'(bad), 32'd0);
        end
        chk("done and error together", 32'(both_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
